// File: rtl/regfile_pkg.sv
// Shared register-file definitions: control polarities, zero word, bus widths
// and the architectural register count.
package regfile_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        ReadEnable  = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam int unsigned RegBus      = 32;
    localparam int unsigned RegAddrBus  = 5;
    localparam int unsigned RegNum      = 32;

endpackage

// File: rtl/regfile.sv
// Two-read / one-write register file with a registered debug read port.
// Register 0 is hard-wired to zero. Define REGFILE_BYPASS_EN to forward a
// same-cycle write to the read ports; otherwise reads see pre-write storage.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RegBus,
    parameter int unsigned ADDR_W   = RegAddrBus,
    parameter int unsigned NUM_REGS = RegNum
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [DATA_W-1:0] Zero = DATA_W'(ZeroWord);

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic [DATA_W-1:0] dbg_data_q;
    logic [DATA_W-1:0] dbg_data_d;

    // Next-state storage: apply the write, keep entry 0 constant so it folds away.
    always_comb begin
        mem_d = mem_q;
        if (we == WriteEnable && waddr != '0) begin
            mem_d[waddr] = wdata;
        end
        mem_d[0] = Zero;
    end

    // Debug capture samples storage before this edge's write.
    always_comb begin
        dbg_data_d = (dbg_addr == '0) ? Zero : mem_q[dbg_addr];
    end

    // Storage and debug register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= Zero;
            end
            dbg_data_q <= Zero;
        end else begin
            mem_q      <= mem_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    // Read port 1: zero when disabled, in reset or addressing r0.
    always_comb begin
        rdata1 = Zero;
        if (rst != RstEnable && re1 == ReadEnable && raddr1 != '0) begin
            if (BypassEn && we == WriteEnable && waddr == raddr1) begin
                rdata1 = wdata;
            end else begin
                rdata1 = mem_q[raddr1];
            end
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        rdata2 = Zero;
        if (rst != RstEnable && re2 == ReadEnable && raddr2 != '0) begin
            if (BypassEn && we == WriteEnable && waddr == raddr2) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem_q[raddr2];
            end
        end
    end

    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vectors plus a random run, all
// compared every negedge against an array model of the register file.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32] = '{default: 32'h0};
    logic [31:0] model_dbg = 32'h0;

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
        if (rst || !re || ra == 5'd0) return 32'h0;
        if (Byp && we && waddr == ra) return wdata;
        return model[ra];
    endfunction

    // Reference storage: reset clears everything, r0 is never written.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'h0;
            model_dbg <= 32'h0;
        end else begin
            model_dbg <= (dbg_addr == 5'd0) ? 32'h0 : model[dbg_addr];
            if (we && waddr != 5'd0) model[waddr] <= wdata;
        end
    end

    // Compare all outputs every cycle, away from the active edge.
    always @(negedge clk) begin
        check("cyc_rdata1", rdata1, exp_read(re1, raddr1));
        check("cyc_rdata2", rdata2, exp_read(re2, raddr2));
        check("cyc_dbg", dbg_data, model_dbg);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0; dbg_addr = '0;
        #1 rst = 1'b1;
        #2 re1 = 1'b1; raddr1 = 5'd5;
        #1 check("rst_init_rdata1", rdata1, 32'h0);
        check("rst_init_dbg", dbg_data, 32'h0);
        cyc(); cyc();
        rst = 1'b0; re1 = 1'b0;

        // Write r7, read back next cycle, then disable the port.
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        cyc();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd7;
        #1 check("r7_read", rdata1, 32'hDEAD_BEEF);
        re1 = 1'b0;
        #1 check("r7_re_off", rdata1, 32'h0);

        // r0 write is discarded, reads of r0 are zero even with bypass condition.
        cyc();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
        #1 check("r0_byp_rd1", rdata1, 32'h0);
        check("r0_byp_rd2", rdata2, 32'h0);
        cyc();
        we = 1'b0;
        #1 check("r0_after_rd1", rdata1, 32'h0);
        check("r0_after_rd2", rdata2, 32'h0);

        // Same-cycle write and read of r3.
        we = 1'b1; waddr = 5'd3; wdata = 32'h1111_1111; re1 = 1'b0; re2 = 1'b0;
        cyc();
        wdata = 32'h2222_2222; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd3; raddr2 = 5'd3;
        #1 check("r3_same_rd1", rdata1, Byp ? 32'h2222_2222 : 32'h1111_1111);
        check("r3_same_rd2", rdata2, Byp ? 32'h2222_2222 : 32'h1111_1111);
        cyc();
        we = 1'b0;
        #1 check("r3_next_rd1", rdata1, 32'h2222_2222);
        check("r3_next_rd2", rdata2, 32'h2222_2222);

        // Debug port: one cycle latency, no bypass.
        re1 = 1'b0; re2 = 1'b0;
        we = 1'b1; waddr = 5'd31; wdata = 32'h5A5A_0001;
        cyc();
        wdata = 32'hA5A5_A5A5; dbg_addr = 5'd31;
        cyc();
        we = 1'b0;
        #1 check("dbg_old", dbg_data, 32'h5A5A_0001);
        cyc();
        #1 check("dbg_new", dbg_data, 32'hA5A5_A5A5);

        // Asynchronous reset mid-cycle clears storage and debug immediately.
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
        cyc();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd5; dbg_addr = 5'd5;
        cyc();
        #1 check("r5_read", rdata1, 32'h1234_5678);
        check("r5_dbg", dbg_data, 32'h1234_5678);
        rst = 1'b1;
        #1 check("r5_async_rd", rdata1, 32'h0);
        check("r5_async_dbg", dbg_data, 32'h0);

        // Write during reset is ignored; first write after release is accepted.
        we = 1'b1; waddr = 5'd9; wdata = 32'h9999_9999;
        cyc();
        rst = 1'b0; we = 1'b0; re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd5;
        #1 check("r9_rst_write", rdata1, 32'h0);
        check("r5_cleared", rdata2, 32'h0);
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0077; re1 = 1'b0;
        cyc();
        we = 1'b0; re1 = 1'b1;
        #1 check("r9_first_write", rdata1, 32'h0000_0077);

        // Random traffic, narrowed addresses so collisions are frequent.
        for (int n = 0; n < 10000; n++) begin
            cyc();
            rst    = ($urandom_range(0, 499) == 0);
            we     = 1'($urandom_range(0, 1));
            re1    = 1'($urandom_range(0, 1));
            re2    = 1'($urandom_range(0, 1));
            waddr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            raddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            dbg_addr = 5'($urandom_range(0, 31));
            wdata  = $urandom;
        end
        cyc();
        rst = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter NUM_REGS, default 32, architectural register count (2**ADDR_W).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_W  write register address.
REQ-008 SHALL have port wdata  input  DATA_W  write data.
REQ-009 SHALL have port re1  input  1  read port 1 enable (driven by decode stage).
REQ-010 SHALL have port raddr1  input  ADDR_W  read port 1 address.
REQ-011 SHALL have port rdata1  output  DATA_W  read port 1 data.
REQ-012 SHALL have port re2  input  1  read port 2 enable.
REQ-013 SHALL have port raddr2  input  ADDR_W  read port 2 address.
REQ-014 SHALL have port rdata2  output  DATA_W  read port 2 data.
REQ-015 SHALL have port dbg_addr  input  ADDR_W  debug read address.
REQ-016 SHALL have port dbg_data  output  DATA_W  debug read data, registered.

Function
REQ-017 SHALL hold NUM_REGS x DATA_W storage; register 0 SHALL read as zero at all times, not stored.
REQ-018 SHALL write wdata to storage[waddr] on rising clk when we=1, rst=0 and waddr!=0; waddr=0 writes SHALL be discarded.
REQ-019 SHALL drive rdataN combinationally (zero-cycle latency) from storage[raddrN] when reN=1 and rst=0.
REQ-020 SHALL drive rdataN = 0 when reN=0, raddrN=0, or rst=1.
REQ-021 SHALL resolve simultaneous same-address write and read per REQ-029/REQ-030; both read ports SHALL apply identical rules independently.
REQ-022 SHALL register dbg_data <= storage[dbg_addr] (0 for address 0) each rising clk; latency exactly one cycle, no bypass; value reflects storage before that edge's write.
REQ-023 SHALL accept any combination of we, re1, re2 in the same cycle with no stalls or handshakes.
REQ-024 SHALL keep storage unchanged when we=0.

Reset
REQ-025 SHALL clear all storage entries to 0 asynchronously on rst=1.
REQ-026 SHALL clear dbg_data to 0 asynchronously on rst=1.
REQ-027 SHALL ignore a write coinciding with a clk edge while rst=1; first write accepted on first rising edge after rst falls.
REQ-028 SHALL return 0 on rdata1/rdata2 throughout reset, irrespective of enables.

Configuration
REQ-029 With macro REGFILE_BYPASS_EN defined, SHALL forward: rdataN = wdata when reN=1, we=1, waddr=raddrN, raddrN!=0, rst=0.
REQ-030 Without REGFILE_BYPASS_EN, SHALL return the pre-write storage value in that case; new value visible from next cycle.

Structure
REQ-031 SHALL take RstEnable, WriteEnable, ReadEnable, ZeroWord, RegBus, RegAddrBus, RegNum from the shared defines package; no local redefinition.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 Reset: assert rst mid-run after writing r5=32'h1234_5678 -> r5 reads 0, dbg_data=0 immediately, without a clk edge.
REQ-034 Write/read: write r7=32'hDEAD_BEEF, next cycle re1=1 raddr1=7 -> rdata1=32'hDEAD_BEEF; re1=0 -> rdata1=0.
REQ-035 r0: we=1 waddr=0 wdata=32'hFFFF_FFFF, then read r0 on both ports with bypass condition active -> 0 both ports.
REQ-036 Bypass: r3 holds 32'h1111_1111; same cycle we=1 waddr=3 wdata=32'h2222_2222, re1=re2=1 raddr1=raddr2=3 -> 32'h2222_2222 with REGFILE_BYPASS_EN, 32'h1111_1111 without.
REQ-037 Debug: write r31=32'hA5A5_A5A5 at edge N with dbg_addr=31 -> dbg_data=32'hA5A5_A5A5 after edge N+1, old value after edge N.
REQ-038 Random: 10k cycles random we/re/addresses vs. reference model, both macro settings -> zero mismatches.
